// File: rtl/hex_tx_pkg.sv
// Shared types and ASCII constants for the hex print sequencer.
package hex_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    CR    = 2'd2,
    LF    = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam logic [7:0] ASCII_0          = 8'h30;
  localparam logic [7:0] ASCII_A_MINUS_10 = 8'h37;

endpackage

// File: rtl/hex_tx_sequencer_nibble2ascii.sv
// Combinational nibble to uppercase ASCII hex digit converter.
import hex_tx_pkg::*;

module nibble2ascii (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  // Digits map from '0', letters from 'A' offset down by ten.
  always_comb begin
    o_ascii = 8'h00;
    if (i_nibble < 4'd10) begin
      o_ascii = ASCII_0 + {4'h0, i_nibble};
    end else begin
      o_ascii = ASCII_A_MINUS_10 + {4'h0, i_nibble};
    end
  end

endmodule

// File: rtl/hex_tx_sequencer.sv
// Prints a captured binary word as ASCII hex (MSB nibble first), optionally
// followed by CR LF, over a valid/ready byte stream.
import hex_tx_pkg::*;

module hex_tx_sequencer #(
  parameter int NBYTES      = 2,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NBYTES*8-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int NDIGITS = NBYTES * 2;
  localparam int IDX_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [NBYTES*8-1:0] r_word;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
  logic [7:0]          r_out_data;

  state_t              w_nxt_state;
  logic [IDX_W-1:0]    w_nxt_idx;
  logic [NBYTES*8-1:0] w_nxt_word;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic [3:0]          w_nibble;
  logic [7:0]          w_ascii;
  logic [7:0]          w_nxt_out_data;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Next-state logic; the output register is loaded from the next state so
  // the first digit appears one cycle after acceptance with no extra stage.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_word  = r_word;
    case (r_state)
      IDLE: begin
        if (w_in_xfer) begin
          w_nxt_state = DIGIT;
          w_nxt_idx   = IDX_LAST;
          w_nxt_word  = in_data;
        end else begin
          w_nxt_state = IDLE;
        end
      end
      DIGIT: begin
        if (w_out_xfer) begin
          if (r_idx != IDX_ZERO) begin
            w_nxt_idx = r_idx - IDX_ONE;
          end else begin
            w_nxt_state = APPEND_CRLF ? CR : IDLE;
          end
        end else begin
          w_nxt_state = DIGIT;
        end
      end
      CR: begin
        if (w_out_xfer) begin
          w_nxt_state = LF;
        end else begin
          w_nxt_state = CR;
        end
      end
      LF: begin
        if (w_out_xfer) begin
          w_nxt_state = IDLE;
        end else begin
          w_nxt_state = LF;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  assign w_nibble = w_nxt_word[{w_nxt_idx, 2'b00} +: 4];

  nibble2ascii u_nibble2ascii (
    .i_nibble (w_nibble),
    .o_ascii  (w_ascii)
  );

  // Character selection for the upcoming output cycle.
  always_comb begin
    w_nxt_out_data = 8'h00;
    case (w_nxt_state)
      DIGIT:   w_nxt_out_data = w_ascii;
      CR:      w_nxt_out_data = ASCII_CR;
      LF:      w_nxt_out_data = ASCII_LF;
      default: w_nxt_out_data = 8'h00;
    endcase
  end

  // State, captured word and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= IDX_ZERO;
      r_word      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_data  <= 8'h00;
    end else begin
      r_state     <= w_nxt_state;
      r_idx       <= w_nxt_idx;
      r_word      <= w_nxt_word;
      r_in_ready  <= (w_nxt_state == IDLE);
      r_out_valid <= (w_nxt_state != IDLE);
      r_busy      <= (w_nxt_state != IDLE);
      r_out_data  <= w_nxt_out_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_hex_tx_sequencer.sv
// Scoreboard bench: three instances (2B+CRLF, 2B digits only, 8B+CRLF).
module tb_hex_tx_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [15:0] a_in_data;
  logic [7:0]  a_out_data;
  logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [15:0] b_in_data;
  logic [7:0]  b_out_data;
  logic        c_rst, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [63:0] c_in_data;
  logic [7:0]  c_out_data;

  hex_tx_sequencer #(.NBYTES(2), .APPEND_CRLF(1'b1)) u_a (
    .clk(clk), .rst(a_rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .busy(a_busy));
  hex_tx_sequencer #(.NBYTES(2), .APPEND_CRLF(1'b0)) u_b (
    .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .busy(b_busy));
  hex_tx_sequencer #(.NBYTES(8), .APPEND_CRLF(1'b1)) u_c (
    .clk(clk), .rst(c_rst), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .busy(c_busy));

  int total = 0;
  int bad   = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];
  int a_xfers = 0;
  int c_xfers = 0;
  logic       a_stall = 1'b0;
  logic [7:0] a_held  = 8'h00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else return 8'h41 + ({4'h0, n} - 8'd10);
  endfunction

  task automatic push_a(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) q_a.push_back(hexc(w[i*4 +: 4]));
    q_a.push_back(8'h0D);
    q_a.push_back(8'h0A);
  endtask

  // Output monitors: pop expected byte whenever a transfer is about to occur.
  always @(negedge clk) begin
    if (a_rst) begin
      a_stall <= 1'b0;
    end else begin
      if (a_stall) begin
        check("a_hold_valid", a_out_valid, 1);
        check("a_hold_data", a_out_data, a_held);
      end
      a_stall <= a_out_valid && !a_out_ready;
      a_held  <= a_out_data;
      if (a_out_valid && a_out_ready) begin
        check("a_byte_expected", q_a.size() != 0, 1);
        if (q_a.size() != 0) check("a_byte", a_out_data, q_a.pop_front());
        a_xfers <= a_xfers + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!b_rst && b_out_valid && b_out_ready) begin
      check("b_byte_expected", q_b.size() != 0, 1);
      if (q_b.size() != 0) check("b_byte", b_out_data, q_b.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!c_rst && c_out_valid && c_out_ready) begin
      check("c_byte_expected", q_c.size() != 0, 1);
      if (q_c.size() != 0) check("c_byte", c_out_data, q_c.pop_front());
      c_xfers <= c_xfers + 1;
    end
  end

  task automatic send_a(input logic [15:0] w);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_in_ready) break;
    end
    check("a_ready_wait", a_in_ready, 1);
    a_in_data  = w;
    a_in_valid = 1'b1;
    push_a(w);
    @(posedge clk);
    #1 a_in_valid = 1'b0;
  endtask

  task automatic drain_a(input bit random_ready);
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (q_a.size() == 0 && !a_busy) break;
      a_out_ready = random_ready ? 1'($urandom_range(0, 1)) : pat[k % 4];
      k++;
    end
    a_out_ready = 1'b1;
    check("a_drained", (q_a.size() == 0) && !a_busy, 1);
  endtask

  initial begin
    int start;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
    a_in_data = 16'h0; b_in_data = 16'h0; c_in_data = 64'h0;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {a_in_ready, b_in_ready, c_in_ready}, 3'b111);
    check("rst_out_valid", {a_out_valid, b_out_valid, c_out_valid}, 3'b000);
    check("rst_busy", {a_busy, b_busy, c_busy}, 3'b000);
    check("rst_out_data", {a_out_data, b_out_data, c_out_data}, 24'h0);

    // 1A2F at full rate: six consecutive characters then one idle cycle
    send_a(16'h1A2F);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("a_burst_valid", a_out_valid, 1);
      check("a_burst_in_ready", a_in_ready, 0);
      check("a_burst_busy", a_busy, 1);
    end
    @(negedge clk);
    check("a_end_valid", a_out_valid, 0);
    check("a_end_in_ready", a_in_ready, 1);
    check("a_end_busy", a_busy, 0);
    check("a_burst_count", q_a.size(), 0);

    // same word with backpressure pattern 1,0,0,1
    send_a(16'h1A2F);
    drain_a(1'b0);

    // new word held on in_valid while busy must wait for IDLE
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_in_ready) break;
    end
    a_in_data = 16'h1234; a_in_valid = 1'b1; push_a(16'h1234);
    @(posedge clk);
    #1 a_in_data = 16'hBEEF; push_a(16'hBEEF);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_in_ready) break;
    end
    check("a_beef_after_idle", q_a.size(), 6);
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    drain_a(1'b0);

    // reset after second digit of CAFE
    start = a_xfers;
    send_a(16'hCAFE);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (a_xfers == start + 2) break;
    end
    check("a_two_digits", a_xfers - start, 2);
    @(posedge clk);
    #1 a_rst = 1'b1;
    q_a.delete();
    @(posedge clk);
    #1 a_rst = 1'b0;
    @(negedge clk);
    check("a_abort_valid", a_out_valid, 0);
    check("a_abort_in_ready", a_in_ready, 1);
    check("a_abort_busy", a_busy, 0);
    send_a(16'h0001);
    drain_a(1'b0);

    // random words under random backpressure
    for (int n = 0; n < 3; n++) begin
      send_a(16'($urandom));
      drain_a(1'b1);
    end

    // digits only: busy falls the cycle after the last digit
    for (int i = 3; i >= 0; i--) q_b.push_back(hexc(4'(16'h09F0 >> (i * 4))));
    @(negedge clk);
    b_in_data = 16'h09F0; b_in_valid = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b_digit_busy", {b_out_valid, b_busy}, 2'b11);
    end
    @(negedge clk);
    check("b_end_busy", {b_out_valid, b_busy, b_in_ready}, 3'b001);
    check("b_queue_empty", q_b.size(), 0);

    // all sixteen nibble values through the wide instance
    for (int i = 15; i >= 0; i--) q_c.push_back(hexc(4'(64'h0123456789ABCDEF >> (i * 4))));
    q_c.push_back(8'h0D);
    q_c.push_back(8'h0A);
    @(negedge clk);
    c_in_data = 64'h0123456789ABCDEF; c_in_valid = 1'b1;
    @(posedge clk);
    #1 c_in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q_c.size() == 0 && !c_busy) break;
    end
    check("c_drained", (q_c.size() == 0) && !c_busy, 1);
    check("c_count", c_xfers, 18);

    check("a_final_queue", q_a.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_tx_sequencer.md
Name: hex_tx_sequencer

Overview:
- Accepts an NBYTES-wide binary word and emits its hexadecimal representation as a stream of ASCII bytes, MSB nibble first, over a valid/ready byte interface.
- Optionally appends CR LF after the last digit.
- Sits between keyboard/scan-code capture logic and the UART transmitter or on-screen text buffer.
- Owns a single nibble-to-ASCII converter and time-multiplexes it across all nibbles of the captured word.

Parameters:
- NBYTES, 2, width of input word in bytes; digits per word = NBYTES*2.
- APPEND_CRLF, 1, 1 = send 8'h0D then 8'h0A after the last digit; 0 = digits only.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NBYTES*8  binary word to print.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; transfer when in_valid && in_ready at a clk edge.
- out_data  output  8  ASCII character.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts out_data; transfer when out_valid && out_ready at a clk edge.
- busy  output  1  high from word acceptance until the final character transfer completes.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=8'h00, busy=0, state=IDLE, digit index=0, captured word=0.
- States: IDLE, DIGIT, CR, LF.
- IDLE:
  - in_ready=1.
  - On input transfer: capture in_data, set index=NBYTES*2-1, go to DIGIT, assert busy.
  - out_valid rises on the cycle after acceptance (1-cycle latency).
- DIGIT:
  - out_valid=1; out_data = ASCII of nibble[index] of the captured word.
  - Conversion: 0..9 -> 8'h30..8'h39; A..F -> 8'h41..8'h46 (uppercase).
  - On output transfer with index>0: decrement index; next digit is presented the following cycle with no bubble.
  - On output transfer with index==0: go to CR if APPEND_CRLF=1, else to IDLE.
- CR: out_data=8'h0D, out_valid=1; on transfer go to LF.
- LF: out_data=8'h0A, out_valid=1; on transfer go to IDLE.
- Entering IDLE: out_valid=0 and busy=0 on the same cycle; in_ready=1. No back-to-back word acceptance on the cycle of the final transfer.
- Backpressure: while out_valid && !out_ready, out_data, state and index are held stable (AXI-stream rule). out_valid never drops without a transfer, except on rst.
- in_valid while not in IDLE is ignored (in_ready=0); in_data changes after capture have no effect.
- Throughput with out_ready tied high: NBYTES*2 (+2 with CRLF) characters on consecutive cycles, then one IDLE cycle before the next accept.
- rst mid-sequence: abort immediately, drop remaining characters, return to reset values the next cycle.
- The index counter is $clog2(NBYTES*2) bits wide, minimum 1. It must never wrap; the decrement only happens when index>0.

Decomposition:
- Shared package hex_tx_pkg:
  - state enum {IDLE, DIGIT, CR, LF}
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0=8'h30, ASCII_A_MINUS_10=8'h37
- Sub-module nibble2ascii: purely combinational, 4-bit in, 8-bit out. One instance, fed by a mux on the captured word selected by the index.
- Output register in the top level.

Test Plan:
- NBYTES=2, APPEND_CRLF=1, out_ready=1, send 16'h1A2F -> out bytes 31,41,32,46,0D,0A on 6 consecutive cycles, starting 1 cycle after accept; in_ready low for those 6 cycles, high the cycle after.
- Same word, out_ready toggling 1,0,0,1,... -> identical byte sequence; out_data stable and out_valid high throughout each stall; no byte lost or duplicated.
- APPEND_CRLF=0, send 16'h09F0 -> 30,39,46,30 only; busy falls on the cycle after the last transfer.
- in_valid held high with new data (16'hBEEF) during a transfer of 16'h1234 -> only 31,32,33,34(,0D,0A) emitted; BEEF accepted only after returning to IDLE.
- Assert rst after the second digit of 16'hCAFE -> next cycle out_valid=0, in_ready=1, busy=0; subsequent word 16'h0001 prints 30,30,30,31 cleanly.
- Sweep all nibbles: NBYTES=8, word 64'h0123456789ABCDEF -> 30..39,41..46 in order; checks the index counter end-to-end with no wrap.
